// File: rtl/alu_ctrl_exec_if.sv
// Operand/control request and result bundle between the EX-stage issue logic
// and the ALU execution unit.
interface alu_ctrl_exec_if #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
);
   logic             start;
   logic [2:0]       operation;
   logic [5:0]       func;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             valid;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, operation, func, shamt, a, b,
      input  result, zero, valid, busy, hi, lo
   );

   modport slave (
      input  start, operation, func, shamt, a, b,
      output result, zero, valid, busy, hi, lo
   );
endinterface

// File: rtl/alu_ctrl_exec.sv
// EX-stage ALU: decodes operation/func, executes single-cycle ops with a
// registered result, and runs multiply/divide iteratively into HI/LO.
module alu_ctrl_exec #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic            clk,
   input logic            rst_n,
   alu_ctrl_exec_if.slave bus
);

   localparam logic [3:0] OP_ADD   = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,
                          OP_OR    = 4'd3,  OP_SLT  = 4'd4,  OP_SLTU = 4'd5,
                          OP_SLL   = 4'd6,  OP_SRL  = 4'd7,  OP_SRA  = 4'd8,
                          OP_MFHI  = 4'd9,  OP_MFLO = 4'd10, OP_MULT = 4'd11,
                          OP_MULTU = 4'd12, OP_DIV  = 4'd13, OP_DIVU = 4'd14;

   localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2;
   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

   logic [3:0]         op_sel;
   logic [WIDTH-1:0]   alu_out;
   logic               is_muldiv, is_signed, is_div;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [1:0]         state;
   logic [SHW-1:0]     cnt;
   logic [WIDTH-1:0]   opa, opb;
   logic               sa, sb;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   result_q, hi_q, lo_q;
   logic               zero_q, valid_q;
   logic [WIDTH-1:0]   mul_add;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift, div_trial;
   logic               div_ok;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   fin_hi, fin_lo;

   always_comb begin
      op_sel = OP_SLL;
      case (bus.operation)
         3'b000: begin
            case (bus.func)
               6'b100000: op_sel = OP_ADD;
               6'b100010: op_sel = OP_SUB;
               6'b100100: op_sel = OP_AND;
               6'b100101: op_sel = OP_OR;
               6'b000000: op_sel = OP_SLL;
               6'b000010: op_sel = OP_SRL;
               6'b000011: op_sel = OP_SRA;
               6'b101010: op_sel = OP_SLT;
               6'b101011: op_sel = OP_SLTU;
               6'b010000: op_sel = OP_MFHI;
               6'b010010: op_sel = OP_MFLO;
               6'b011000: op_sel = OP_MULT;
               6'b011001: op_sel = OP_MULTU;
               6'b011010: op_sel = OP_DIV;
               6'b011011: op_sel = OP_DIVU;
               default:   op_sel = OP_SLL;
            endcase
         end
         3'b001:  op_sel = OP_ADD;
         3'b010:  op_sel = OP_SUB;
         3'b011:  op_sel = OP_AND;
         3'b100:  op_sel = OP_OR;
         3'b101:  op_sel = OP_SLT;
         default: op_sel = OP_SLL;
      endcase
   end

   always_comb begin
      alu_out = '0;
      case (op_sel)
         OP_ADD:  alu_out = bus.a + bus.b;
         OP_SUB:  alu_out = bus.a - bus.b;
         OP_AND:  alu_out = bus.a & bus.b;
         OP_OR:   alu_out = bus.a | bus.b;
         OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
         OP_SLL:  alu_out = bus.b << bus.shamt;
         OP_SRL:  alu_out = bus.b >> bus.shamt;
         OP_SRA:  alu_out = $signed(bus.b) >>> bus.shamt;
         OP_MFHI: alu_out = hi_q;
         OP_MFLO: alu_out = lo_q;
         default: alu_out = '0;
      endcase
   end

   // Signed mult/div iterate on magnitudes; the sign flags fix up the result.
   assign is_muldiv = (op_sel == OP_MULT) || (op_sel == OP_MULTU) ||
                      (op_sel == OP_DIV)  || (op_sel == OP_DIVU);
   assign is_signed = (op_sel == OP_MULT) || (op_sel == OP_DIV);
   assign is_div    = (op_sel == OP_DIV)  || (op_sel == OP_DIVU);
   assign a_neg     = is_signed & bus.a[WIDTH-1];
   assign b_neg     = is_signed & bus.b[WIDTH-1];
   assign a_mag     = a_neg ? -bus.a : bus.a;
   assign b_mag     = b_neg ? -bus.b : bus.b;

   assign mul_add   = acc[0] ? opa : '0;
   assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
   assign mul_next  = {mul_sum, acc[WIDTH-1:1]};

   assign div_shift = acc[2*WIDTH-1:WIDTH-1];
   assign div_trial = div_shift - {1'b0, opb};
   assign div_ok    = ~div_trial[WIDTH];
   assign div_next  = {(div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                       acc[WIDTH-2:0], div_ok};

   // Final HI/LO as they will be written on the last iteration edge.
   always_comb begin
      prod   = (sa ^ sb) ? -mul_next : mul_next;
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
      if (state == S_DIV) begin
         if (opb == '0) begin
            fin_lo = '1;
            fin_hi = sa ? -opa : opa;
         end else begin
            fin_lo = (sa ^ sb) ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
            fin_hi = sa ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         opa      <= '0;
         opb      <= '0;
         sa       <= 1'b0;
         sb       <= 1'b0;
         acc      <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
         valid_q  <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  if (is_muldiv) begin
                     opa   <= a_mag;
                     opb   <= b_mag;
                     sa    <= a_neg;
                     sb    <= b_neg;
                     acc   <= is_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                     cnt   <= '0;
                     state <= is_div ? S_DIV : S_MUL;
                  end else begin
                     result_q <= alu_out;
                     zero_q   <= (alu_out == '0);
                     valid_q  <= 1'b1;
                  end
               end
            end
            S_MUL, S_DIV: begin
               acc <= (state == S_MUL) ? mul_next : div_next;
               cnt <= cnt + SHW'(1);
               if (cnt == LAST) begin
                  hi_q     <= fin_hi;
                  lo_q     <= fin_lo;
                  result_q <= fin_lo;
                  zero_q   <= (fin_lo == '0);
                  valid_q  <= 1'b1;
                  cnt      <= '0;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.result = result_q;
   assign bus.zero   = zero_q;
   assign bus.valid  = valid_q;
   assign bus.busy   = (state != S_IDLE);
   assign bus.hi     = hi_q;
   assign bus.lo     = lo_q;

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Scoreboard bench for alu_ctrl_exec: a 32-bit and an 8-bit instance, expected
// results queued at issue and compared when valid rises.
module tb_alu_ctrl_exec;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_ctrl_exec_if #(.WIDTH(32)) bus32 ();
   alu_ctrl_exec_if #(.WIDTH(8))  bus8 ();

   alu_ctrl_exec #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
   alu_ctrl_exec #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   typedef struct {
      logic [2:0]  op;
      logic [5:0]  fn;
      logic [4:0]  sh;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
   } sc_t;

   typedef struct {
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } md_t;

   exp_t q32[$];
   exp_t q8[$];
   int   checks = 0;
   int   errors = 0;
   logic [31:0] mhi = '0, mlo = '0, mres = '0;

   task automatic drive32(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] er, input logic [31:0] ehi, input logic [31:0] elo);
      exp_t e;
      bus32.start     = 1'b1;
      bus32.operation = op;
      bus32.func      = fn;
      bus32.shamt     = sh;
      bus32.a         = av;
      bus32.b         = bv;
      e.res = er; e.zero = (er == 32'd0); e.hi = ehi; e.lo = elo;
      q32.push_back(e);
   endtask

   task automatic drive8(input logic [2:0] op, input logic [5:0] fn, input logic [2:0] sh,
                         input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] er, input logic [7:0] ehi, input logic [7:0] elo);
      exp_t e;
      bus8.start     = 1'b1;
      bus8.operation = op;
      bus8.func      = fn;
      bus8.shamt     = sh;
      bus8.a         = av;
      bus8.b         = bv;
      e.res = {24'd0, er}; e.zero = (er == 8'd0); e.hi = {24'd0, ehi}; e.lo = {24'd0, elo};
      q8.push_back(e);
   endtask

   // Bounded wait for valid; start is dropped after the issuing edge.
   task automatic wait32(input int max, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         bus32.start = 1'b0;
      end while (!bus32.valid && cyc < max);
   endtask

   task automatic wait8(input int max, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         bus8.start = 1'b0;
      end while (!bus8.valid && cyc < max);
   endtask

   task automatic test_reset();
      bus32.start = 0; bus32.operation = 0; bus32.func = 0; bus32.shamt = 0; bus32.a = 0; bus32.b = 0;
      bus8.start = 0;  bus8.operation = 0;  bus8.func = 0;  bus8.shamt = 0;  bus8.a = 0;  bus8.b = 0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus32.result, bus32.zero, bus32.valid, bus32.busy, bus32.hi, bus32.lo} !==
          {32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0}) begin
         errors++;
         $display("[TB] FAIL reset32: got r=%h z=%b v=%b busy=%b hi=%h lo=%h, expected r=0 z=1 v=0 busy=0 hi=0 lo=0",
                  bus32.result, bus32.zero, bus32.valid, bus32.busy, bus32.hi, bus32.lo);
      end
      checks++;
      if ({bus8.result, bus8.zero, bus8.valid, bus8.busy, bus8.hi, bus8.lo} !==
          {8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
         errors++;
         $display("[TB] FAIL reset8: got r=%h z=%b v=%b busy=%b hi=%h lo=%h, expected r=0 z=1 v=0 busy=0 hi=0 lo=0",
                  bus8.result, bus8.zero, bus8.valid, bus8.busy, bus8.hi, bus8.lo);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      sc_t   v[17];
      string nm[17];
      exp_t  e;
      int    cyc;
      v[0]  = '{3'b000, 6'b100000, 5'd0,  32'd7,        32'd5,        32'd12};        nm[0]  = "add";
      v[1]  = '{3'b000, 6'b100010, 5'd0,  32'd5,        32'd5,        32'd0};         nm[1]  = "sub_zero";
      v[2]  = '{3'b000, 6'b000011, 5'd4,  32'd0,        32'h80000000, 32'hF8000000};  nm[2]  = "sra";
      v[3]  = '{3'b000, 6'b101010, 5'd0,  32'hFFFFFFFF, 32'd1,        32'd1};         nm[3]  = "slt";
      v[4]  = '{3'b000, 6'b101011, 5'd0,  32'hFFFFFFFF, 32'd1,        32'd0};         nm[4]  = "sltu";
      v[5]  = '{3'b000, 6'b111111, 5'd2,  32'd0,        32'd3,        32'd12};        nm[5]  = "badfunc_sll";
      v[6]  = '{3'b000, 6'b000010, 5'd4,  32'd0,        32'h80000000, 32'h08000000};  nm[6]  = "srl";
      v[7]  = '{3'b000, 6'b000000, 5'd31, 32'd0,        32'd1,        32'h80000000};  nm[7]  = "sll31";
      v[8]  = '{3'b000, 6'b100100, 5'd0,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000};  nm[8]  = "and";
      v[9]  = '{3'b000, 6'b100101, 5'd0,  32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF};  nm[9]  = "or";
      v[10] = '{3'b001, 6'b011000, 5'd0,  32'hFFFFFFFF, 32'd1,        32'd0};         nm[10] = "op_add_wrap";
      v[11] = '{3'b010, 6'b011000, 5'd0,  32'd0,        32'd1,        32'hFFFFFFFF};  nm[11] = "op_sub_wrap";
      v[12] = '{3'b011, 6'b011000, 5'd0,  32'hC,        32'hA,        32'h8};         nm[12] = "op_and";
      v[13] = '{3'b100, 6'b011000, 5'd0,  32'hC,        32'hA,        32'hE};         nm[13] = "op_or";
      v[14] = '{3'b101, 6'b011000, 5'd0,  32'h80000000, 32'd1,        32'd1};         nm[14] = "op_slt";
      v[15] = '{3'b110, 6'b011010, 5'd3,  32'd9,        32'd1,        32'd8};         nm[15] = "op110_sll";
      v[16] = '{3'b111, 6'b100000, 5'd1,  32'd9,        32'd5,        32'hA};         nm[16] = "op111_sll";
      for (int i = 0; i < 17; i++) begin
         drive32(v[i].op, v[i].fn, v[i].sh, v[i].a, v[i].b, v[i].res, mhi, mlo);
         wait32(4, cyc);
         e = q32.pop_front();
         checks++;
         if (cyc != 1 || {bus32.valid, bus32.result, bus32.zero, bus32.hi, bus32.lo} !==
                         {1'b1, e.res, e.zero, e.hi, e.lo}) begin
            errors++;
            $display("[TB] FAIL %s: got cyc=%0d v=%b r=%h z=%b hi=%h lo=%h, expected cyc=1 v=1 r=%h z=%b hi=%h lo=%h",
                     nm[i], cyc, bus32.valid, bus32.result, bus32.zero, bus32.hi, bus32.lo,
                     e.res, e.zero, e.hi, e.lo);
         end
         mres = e.res;
      end
   endtask

   task automatic test_mult();
      exp_t e;
      int   cyc;
      drive32(3'b000, 6'b011000, 5'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFEB);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         bus32.start = 1'b0;
         if (cyc == 10) begin
            drive32(3'b000, 6'b100000, 5'd0, 32'd1, 32'd1, 32'd2, 32'd0, 32'd0);
            void'(q32.pop_back());
         end
         if (cyc == 20) begin
            checks++;
            if ({bus32.busy, bus32.result, bus32.hi, bus32.lo} !== {1'b1, mres, mhi, mlo}) begin
               errors++;
               $display("[TB] FAIL mult_hold: got busy=%b r=%h hi=%h lo=%h, expected busy=1 r=%h hi=%h lo=%h",
                        bus32.busy, bus32.result, bus32.hi, bus32.lo, mres, mhi, mlo);
            end
         end
      end while (!bus32.valid && cyc < 40);
      e = q32.pop_front();
      checks++;
      if (cyc != 33 || {bus32.valid, bus32.busy, bus32.result, bus32.zero, bus32.hi, bus32.lo} !==
                       {1'b1, 1'b0, e.res, e.zero, e.hi, e.lo}) begin
         errors++;
         $display("[TB] FAIL mult: got cyc=%0d v=%b busy=%b r=%h hi=%h lo=%h, expected cyc=33 v=1 busy=0 r=%h hi=%h lo=%h",
                  cyc, bus32.valid, bus32.busy, bus32.result, bus32.hi, bus32.lo, e.res, e.hi, e.lo);
      end
      mres = e.res; mhi = e.hi; mlo = e.lo;
      @(negedge clk);
      checks++;
      if (bus32.valid !== 1'b0 || bus32.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mult_ignored_start: got v=%b busy=%b, expected v=0 busy=0",
                  bus32.valid, bus32.busy);
      end
   endtask

   task automatic test_div();
      md_t   v[8];
      string nm[8];
      exp_t  e;
      int    cyc;
      v[0] = '{6'b011010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 33}; nm[0] = "div_neg";
      v[1] = '{6'b011011, 32'd7,        32'd0,        32'hFFFFFFFF, 32'd7,        32'hFFFFFFFF, 33}; nm[1] = "divu_by0";
      v[2] = '{6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        32'h80000000, 33}; nm[2] = "div_min_m1";
      v[3] = '{6'b011010, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        32'hFFFFFFFD, 33}; nm[3] = "div_negb";
      v[4] = '{6'b011010, 32'hFFFFFFF7, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF7, 32'hFFFFFFFF, 33}; nm[4] = "div_by0";
      v[5] = '{6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 32'd1,        33}; nm[5] = "multu_max";
      v[6] = '{6'b010000, 32'd0,        32'd0,        32'hFFFFFFFE, 32'hFFFFFFFE, 32'd1,        1};  nm[6] = "mfhi";
      v[7] = '{6'b010010, 32'd0,        32'd0,        32'd1,        32'hFFFFFFFE, 32'd1,        1};  nm[7] = "mflo";
      for (int i = 0; i < 8; i++) begin
         drive32(3'b000, v[i].fn, 5'd0, v[i].a, v[i].b, v[i].res, v[i].hi, v[i].lo);
         wait32(40, cyc);
         e = q32.pop_front();
         checks++;
         if (cyc != v[i].lat || {bus32.valid, bus32.result, bus32.zero, bus32.hi, bus32.lo} !==
                                {1'b1, e.res, e.zero, e.hi, e.lo}) begin
            errors++;
            $display("[TB] FAIL %s: got cyc=%0d v=%b r=%h z=%b hi=%h lo=%h, expected cyc=%0d v=1 r=%h z=%b hi=%h lo=%h",
                     nm[i], cyc, bus32.valid, bus32.result, bus32.zero, bus32.hi, bus32.lo,
                     v[i].lat, e.res, e.zero, e.hi, e.lo);
         end
         mres = e.res; mhi = e.hi; mlo = e.lo;
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   cyc;
      drive32(3'b000, 6'b011011, 5'd0, 32'd100, 32'd7, 32'd14, 32'd2, 32'd14);
      wait32(40, cyc);
      e = q32.pop_front();
      checks++;
      if (cyc != 33 || {bus32.valid, bus32.result, bus32.hi, bus32.lo} !== {1'b1, e.res, e.hi, e.lo}) begin
         errors++;
         $display("[TB] FAIL divu_b2b: got cyc=%0d v=%b r=%h hi=%h lo=%h, expected cyc=33 v=1 r=%h hi=%h lo=%h",
                  cyc, bus32.valid, bus32.result, bus32.hi, bus32.lo, e.res, e.hi, e.lo);
      end
      mhi = e.hi; mlo = e.lo;
      drive32(3'b000, 6'b100000, 5'd0, 32'd2, 32'd3, 32'd5, mhi, mlo);
      wait32(4, cyc);
      e = q32.pop_front();
      checks++;
      if (cyc != 1 || {bus32.valid, bus32.result, bus32.zero, bus32.hi, bus32.lo} !==
                      {1'b1, e.res, e.zero, e.hi, e.lo}) begin
         errors++;
         $display("[TB] FAIL start_on_valid: got cyc=%0d v=%b r=%h z=%b hi=%h lo=%h, expected cyc=1 v=1 r=%h z=%b hi=%h lo=%h",
                  cyc, bus32.valid, bus32.result, bus32.zero, bus32.hi, bus32.lo, e.res, e.zero, e.hi, e.lo);
      end
      mres = e.res;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   cyc;
      drive32(3'b000, 6'b011001, 5'd0, 32'd5, 32'd6, 32'd30, 32'd0, 32'd30);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus32.start = 1'b0;
      end
      checks++;
      if (bus32.busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL multu_busy: got busy=%b, expected busy=1", bus32.busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus32.result, bus32.zero, bus32.valid, bus32.busy, bus32.hi, bus32.lo} !==
          {32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0}) begin
         errors++;
         $display("[TB] FAIL reset_mid: got r=%h z=%b v=%b busy=%b hi=%h lo=%h, expected r=0 z=1 v=0 busy=0 hi=0 lo=0",
                  bus32.result, bus32.zero, bus32.valid, bus32.busy, bus32.hi, bus32.lo);
      end
      q32.delete();
      mhi = '0; mlo = '0; mres = '0;
      @(negedge clk);
      rst_n = 1'b1;
      drive32(3'b000, 6'b010010, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      wait32(4, cyc);
      e = q32.pop_front();
      checks++;
      if (cyc != 1 || {bus32.valid, bus32.result, bus32.zero, bus32.hi, bus32.lo} !==
                      {1'b1, e.res, e.zero, e.hi, e.lo}) begin
         errors++;
         $display("[TB] FAIL mflo_after_reset: got cyc=%0d v=%b r=%h z=%b hi=%h lo=%h, expected cyc=1 v=1 r=%h z=%b hi=%h lo=%h",
                  cyc, bus32.valid, bus32.result, bus32.zero, bus32.hi, bus32.lo, e.res, e.zero, e.hi, e.lo);
      end
   endtask

   task automatic test_width8();
      exp_t       e;
      int         cyc;
      logic [7:0] sa8[4];
      logic [7:0] sb8[4];
      logic [7:0] sum8;
      drive8(3'b000, 6'b011001, 3'd0, 8'hFF, 8'hFF, 8'h01, 8'hFE, 8'h01);
      wait8(20, cyc);
      e = q8.pop_front();
      checks++;
      if (cyc != 9 || {bus8.valid, bus8.result, bus8.hi, bus8.lo} !== {1'b1, e.res[7:0], e.hi[7:0], e.lo[7:0]}) begin
         errors++;
         $display("[TB] FAIL w8_multu: got cyc=%0d v=%b r=%h hi=%h lo=%h, expected cyc=9 v=1 r=%h hi=%h lo=%h",
                  cyc, bus8.valid, bus8.result, bus8.hi, bus8.lo, e.res[7:0], e.hi[7:0], e.lo[7:0]);
      end
      drive8(3'b000, 6'b011010, 3'd0, 8'h80, 8'hFF, 8'h80, 8'h00, 8'h80);
      wait8(20, cyc);
      e = q8.pop_front();
      checks++;
      if (cyc != 9 || {bus8.valid, bus8.result, bus8.hi, bus8.lo} !== {1'b1, e.res[7:0], e.hi[7:0], e.lo[7:0]}) begin
         errors++;
         $display("[TB] FAIL w8_div_min: got cyc=%0d v=%b r=%h hi=%h lo=%h, expected cyc=9 v=1 r=%h hi=%h lo=%h",
                  cyc, bus8.valid, bus8.result, bus8.hi, bus8.lo, e.res[7:0], e.hi[7:0], e.lo[7:0]);
      end
      sa8[0] = 8'h01; sb8[0] = 8'h02;
      sa8[1] = 8'hFF; sb8[1] = 8'h01;
      sa8[2] = 8'h80; sb8[2] = 8'h7F;
      sa8[3] = 8'h10; sb8[3] = 8'h20;
      sum8 = sa8[0] + sb8[0];
      drive8(3'b000, 6'b100000, 3'd0, sa8[0], sb8[0], sum8, 8'h00, 8'h80);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         bus8.start = 1'b0;
         e = q8.pop_front();
         checks++;
         if ({bus8.valid, bus8.result, bus8.zero} !== {1'b1, e.res[7:0], e.zero}) begin
            errors++;
            $display("[TB] FAIL w8_b2b_%0d: got v=%b r=%h z=%b, expected v=1 r=%h z=%b",
                     i - 1, bus8.valid, bus8.result, bus8.zero, e.res[7:0], e.zero);
         end
         if (i < 4) begin
            sum8 = sa8[i] + sb8[i];
            drive8(3'b000, 6'b100000, 3'd0, sa8[i], sb8[i], sum8, 8'h00, 8'h80);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_mult();
      test_div();
      test_back_to_back();
      test_reset_mid();
      test_width8();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
